// File: rtl/bytefifo_pkg.sv
// Shared types and constants for the ByteInputFifo write-side logic.
package bytefifo_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_FLUSH} arb_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int REM_BITS       = $clog2(BYTES_PER_WORD);

    // A legal bytes_valid field names 1..BYTES_PER_WORD bytes of a word.
    function automatic logic bytesLegal(input logic [2:0] bytes);
        return (bytes != 3'd0) && (bytes <= 3'(BYTES_PER_WORD));
    endfunction

endpackage

// File: rtl/byte_fifo_write_arbiter_rr.sv
// Round-robin priority select: first requester at or after the pointer wins, wrapping.
module rr_priority_select #(
    parameter int NUM_PORTS = 4,
    parameter int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IW-1:0]        ptr_i,
    output logic [NUM_PORTS-1:0] onehot_o,
    output logic [IW-1:0]        idx_o,
    output logic                 valid_o
);

    logic [IW:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(off);
            if (cand >= (IW+1)'(NUM_PORTS)) begin
                cand = cand - (IW+1)'(NUM_PORTS);
            end
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                valid_o                  = 1'b1;
                idx_o                    = cand[IW-1:0];
                onehot_o[cand[IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_fifo_write_arbiter.sv
// Shares one ByteInputFifo write port between frame sources, one whole frame per grant,
// and issues a trailing flush when a frame ends on a partial word.
module byte_fifo_write_arbiter
    import bytefifo_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_BITS = 9,
    parameter int MIN_FREE  = 16,
    parameter int LOW_WATER = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    src_req,
    output logic [NUM_PORTS-1:0]    src_grant,
    output logic                    src_ready,
    input  logic [NUM_PORTS-1:0]    src_wr,
    input  logic [NUM_PORTS*32-1:0] src_din,
    input  logic [NUM_PORTS*3-1:0]  src_bytes,
    input  logic [NUM_PORTS-1:0]    src_last,
    output logic                    fifo_wr,
    output logic [31:0]             fifo_din,
    output logic [2:0]              fifo_bytes,
    output logic                    fifo_flush,
    input  logic [ADDR_BITS:0]      fifo_wsize,
    output logic                    proto_err
);

    localparam int IW = $clog2(NUM_PORTS);

    arb_state_t             state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [REM_BITS-1:0]    rem_q, rem_d;
    logic                   err_q, err_d;

    logic [31:0]            dinArr   [NUM_PORTS];
    logic [2:0]             bytesArr [NUM_PORTS];
    logic [NUM_PORTS-1:0]   pickOneHot;
    logic [IW-1:0]          pickIdx;
    logic                   pickValid;
    logic                   roomForFrame, aboveLow;
    logic                   selWr, selLast, accept;
    logic [31:0]            selDin;
    logic [2:0]             selBytes;
    logic [REM_BITS-1:0]    remNext;
    logic                   strayWr, blockedWr, badBytes;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign dinArr[i]   = src_din[32*i +: 32];
        assign bytesArr[i] = src_bytes[3*i +: 3];
    end

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_rr (
        .req_i    (src_req),
        .ptr_i    (ptr_q),
        .onehot_o (pickOneHot),
        .idx_o    (pickIdx),
        .valid_o  (pickValid)
    );

    assign roomForFrame = fifo_wsize >= (ADDR_BITS+1)'(MIN_FREE);
    assign aboveLow     = fifo_wsize >= (ADDR_BITS+1)'(LOW_WATER);

    assign selWr    = src_wr[gidx_q];
    assign selLast  = src_last[gidx_q];
    assign selDin   = dinArr[gidx_q];
    assign selBytes = bytesArr[gidx_q];

    assign src_ready = (state_q == ARB_BUSY) && aboveLow;
    assign accept    = src_ready && selWr;
    assign remNext   = rem_q + selBytes[REM_BITS-1:0];

    assign src_grant  = grant_q;
    assign fifo_wr    = accept;
    assign fifo_din   = accept ? selDin : '0;
    assign fifo_bytes = accept ? selBytes : '0;
    assign fifo_flush = (state_q == ARB_FLUSH);
    assign proto_err  = err_q;

    // Outside BUSY grant_q is zero, so every write counts as stray there.
    assign strayWr   = |(src_wr & ~grant_q);
    assign blockedWr = (state_q == ARB_BUSY) && selWr && !aboveLow;
    assign badBytes  = accept && !bytesLegal(selBytes);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        err_d   = err_q | strayWr | blockedWr | badBytes;
        case (state_q)
            ARB_IDLE: begin
                if (pickValid && roomForFrame) begin
                    grant_d = pickOneHot;
                    gidx_d  = pickIdx;
                    ptr_d   = (pickIdx == IW'(NUM_PORTS-1)) ? '0 : pickIdx + IW'(1);
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (accept) begin
                    rem_d = remNext;
                    if (selLast) begin
                        grant_d = '0;
                        state_d = (remNext != '0) ? ARB_FLUSH : ARB_IDLE;
                    end
                end
            end
            ARB_FLUSH: begin
                rem_d   = '0;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

endmodule
